// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector: LEN-bit history, Moore fill/armed FSM, held Det with Ack handshake.
// Optional overlapping detection is enabled by defining SEQ_OVERLAP_EN.
module seq_detect_ctrl #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             En,
    input  logic             Din,
    input  logic             DinValid,
    input  logic             Ack,
    output logic             Det,
    output logic             Overrun,
    output logic [CNT_W-1:0] MatchCount,
    output logic [1:0]       State
);

    localparam int FILL_W = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_ARMED = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LEN-1:0]     r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_next;
    logic               r_det;
    logic               r_overrun;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic [LEN-1:0]     w_hist_shift;
    logic               w_fill_ok;
    logic               w_match;

    assign w_accept     = En & DinValid;
    assign w_hist_shift = {r_hist[LEN-2:0], Din};
    // fill+1 >= LEN rewritten as fill >= LEN-1 so the sum can never overflow fill's width
    assign w_fill_ok    = (r_fill >= FILL_W'(LEN - 1));
    assign w_match      = w_accept & (w_hist_shift == PATTERN) & w_fill_ok;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_fill  <= '0;
            r_hist  <= '0;
        end else begin
            r_state <= w_state_next;
            r_fill  <= w_fill_next;
            if (w_accept) begin
                r_hist <= w_hist_shift;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        if (!En) begin
            // History is kept across a disable; only the fill level restarts.
            w_state_next = ST_IDLE;
            w_fill_next  = '0;
        end else begin
            if (r_state == ST_IDLE) begin
                w_state_next = ST_FILL;
            end
            if (w_accept) begin
                w_state_next = w_fill_ok ? ST_ARMED : ST_FILL;
                if (r_fill != FILL_W'(LEN)) begin
                    w_fill_next = r_fill + FILL_W'(1);
                end
`ifdef SEQ_OVERLAP_EN
`else
                if (w_match) begin
                    w_fill_next = '0;
                    if (r_state == ST_ARMED) begin
                        w_state_next = ST_FILL;
                    end
                end
`endif
            end
        end
    end

    // A new match always wins over Ack: the fresh event replaces the acknowledged one.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_det     <= 1'b0;
            r_overrun <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_match) begin
                r_det <= 1'b1;
                if (r_det && !Ack) begin
                    r_overrun <= 1'b1;
                end
                if (r_count != {CNT_W{1'b1}}) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (Ack) begin
                r_det <= 1'b0;
            end
        end
    end

    assign Det        = r_det;
    assign Overrun    = r_overrun;
    assign MatchCount = r_count;
    assign State      = r_state;

endmodule
